// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, arbiter FSM states and width defaults.
// Imported by alu_arbiter and by anything that needs to speak the ALU's opcode language.
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int OP_W_DEF   = 4;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;
    localparam logic [3:0] ALU_BEQ  = 4'b1010;
    localparam logic [3:0] ALU_BNE  = 4'b1011;
    localparam logic [3:0] ALU_BLT  = 4'b1100;
    localparam logic [3:0] ALU_BGE  = 4'b1101;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant with round-robin on conflict; define ALU_ARB_FIXED_PRIO_EN for
// fixed priority (port 0 always wins a conflict, i_last_grant then ignored).
module rr_arb2 (
    input  logic       i_en,
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;
`endif

    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        o_grant = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
                2'b11:   o_grant = 2'b01;
`else
                2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
`endif
                default: o_grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters and buffers one response.
// Conflict policy is round-robin unless ALU_ARB_FIXED_PRIO_EN is defined (see rr_arb2).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,
    output logic [DATA_W-1:0] alu_data_one,
    output logic [DATA_W-1:0] alu_data_two,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero
);

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    logic              r_resp_id;
    logic              r_last_grant;
    logic [DATA_W-1:0] r_result;
    logic              r_zero;

    logic              w_owner_ready;
    logic              w_can_issue;
    logic [1:0]        w_grant;
    logic              w_issue;

    // Owner draining the buffer this cycle frees it for a new op in the same cycle.
    assign w_owner_ready = r_resp_id ? rsp1_ready : rsp0_ready;
    assign w_can_issue   = !rst && ((r_state == IDLE) || w_owner_ready);

    rr_arb2 u_rr_arb2 (
        .i_en         (w_can_issue),
        .i_req        ({req1_valid, req0_valid}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    assign w_issue    = |w_grant;
    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    always_comb begin
        alu_data_one = '0;
        alu_data_two = '0;
        alu_op       = '0;
        if (w_grant[0]) begin
            alu_data_one = req0_a;
            alu_data_two = req0_b;
            alu_op       = req0_op;
        end else if (w_grant[1]) begin
            alu_data_one = req1_a;
            alu_data_two = req1_b;
            alu_op       = req1_op;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_issue) w_state_next = RESP;
            RESP:    if (!w_issue && w_owner_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_resp_id    <= 1'b0;
            r_last_grant <= 1'b1;
            r_result     <= '0;
            r_zero       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_issue) begin
                r_result     <= alu_result;
                r_zero       <= alu_zero;
                r_resp_id    <= w_grant[1];
                r_last_grant <= w_grant[1];
            end
        end
    end

    assign rsp0_valid  = (r_state == RESP) && !r_resp_id;
    assign rsp1_valid  = (r_state == RESP) &&  r_resp_id;
    assign rsp0_result = r_result;
    assign rsp1_result = r_result;
    assign rsp0_zero   = r_zero;
    assign rsp1_zero   = r_zero;

endmodule
